// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS PPC-writable 32-bit control registers to fabric,
// with byte-enable writes, read-back, update strobes and optional shadow/commit.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_SHADOW     = 0,
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    output logic [C_NUM_REGS*32-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_update
);
    localparam int AW = C_OPB_AWIDTH;
    localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [AW-1:0] SPAN = C_HIGHADDR[AW-1:0] - C_BASEADDR[AW-1:0];

    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nxt;

    logic [AW:0]   diff;
    logic [AW-3:0] wd;
    logic          hit;
    logic          wr_q, reg_q, cmt_q, unm_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q, merged, rdata, commit_cnt;
    logic          do_reg_wr, do_cmt_wr;
    logic [C_NUM_REGS-1:0][31:0] staged, active;

    // Borrow bit of the extended subtract flags addresses below the window.
    always_comb begin
        diff = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR[AW-1:0]};
        wd   = diff[AW-1:2];
        hit  = OPB_select && !diff[AW] && (diff[AW-1:0] <= SPAN);
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        Sl_xferAck = 1'b0;
        Sl_errAck  = 1'b0;
        Sl_DBus    = '0;
        do_reg_wr  = 1'b0;
        do_cmt_wr  = 1'b0;
        case (state)
            IDLE: if (hit) state_nxt = ACK;
            ACK: begin
                state_nxt  = IDLE;
                Sl_xferAck = 1'b1;
                Sl_errAck  = unm_q;
                if (!wr_q) Sl_DBus = rdata;
                do_reg_wr  = wr_q && reg_q && (|be_q);
                do_cmt_wr  = wr_q && cmt_q && (|be_q);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured on the hit cycle and only consumed during ACK.
    always_ff @(posedge OPB_Clk) begin
        if (state == IDLE && hit) begin
            wr_q    <= !OPB_RNW;
            reg_q   <= wd <  (AW-2)'(C_NUM_REGS);
            cmt_q   <= wd == (AW-2)'(C_NUM_REGS);
            unm_q   <= wd >  (AW-2)'(C_NUM_REGS);
            idx_q   <= wd[IW-1:0];
            be_q    <= OPB_BE;
            wdata_q <= OPB_DBus;
        end
    end

    // be_q[b] covers bits [8b+7:8b] after the OPB bit-order flip.
    always_comb begin
        merged = staged[idx_q];
        for (int b = 0; b < 4; b++)
            if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        rdata = '0;
        if (reg_q)      rdata = staged[idx_q];
        else if (cmt_q) rdata = commit_cnt;
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            staged     <= {C_NUM_REGS{C_INIT_VALUE}};
            commit_cnt <= '0;
        end else begin
            if (do_reg_wr) staged[idx_q] <= merged;
            if (do_cmt_wr) commit_cnt <= commit_cnt + 32'd1;
        end
    end

    generate
        if (C_SHADOW == 0) begin : g_direct
            assign active = staged;
            always_ff @(posedge OPB_Clk) begin
                if (OPB_Rst) user_update <= '0;
                else begin
                    user_update <= '0;
                    if (do_reg_wr) user_update[idx_q] <= 1'b1;
                end
            end
        end else begin : g_shadow
            always_ff @(posedge OPB_Clk) begin
                if (OPB_Rst) begin
                    active      <= {C_NUM_REGS{C_INIT_VALUE}};
                    user_update <= '0;
                end else begin
                    user_update <= do_cmt_wr ? '1 : '0;
                    if (do_cmt_wr) active <= staged;
                end
            end
        end
    endgenerate

    assign user_data_out = active;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, diff[1:0]};
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: one direct-mode and one shadow-mode instance.
module tb_opb_register_bank_ppc2simulink;
    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus, dbus;
    logic [0:3]  be;
    logic        rnw, seq_addr;
    logic [1:0]  sel;
    logic [1:0]  s_ack, s_err, s_retry, s_tout;
    logic [0:31] s_dbus [2];
    logic [127:0] u_data [2];
    logic [3:0]  u_upd [2];

    int n_chk = 0, n_pass = 0;

    typedef struct { logic [31:0] data; logic err; } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(.C_NUM_REGS(4), .C_SHADOW(0), .C_INIT_VALUE(32'hA5A5A5A5)) dut0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel[0]), .OPB_seqAddr(seq_addr),
        .Sl_DBus(s_dbus[0]), .Sl_errAck(s_err[0]), .Sl_retry(s_retry[0]), .Sl_toutSup(s_tout[0]),
        .Sl_xferAck(s_ack[0]), .user_data_out(u_data[0]), .user_update(u_upd[0]));

    opb_register_bank_ppc2simulink #(.C_NUM_REGS(4), .C_SHADOW(1), .C_INIT_VALUE(32'h0)) dut1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel[1]), .OPB_seqAddr(seq_addr),
        .Sl_DBus(s_dbus[1]), .Sl_errAck(s_err[1]), .Sl_retry(s_retry[1]), .Sl_toutSup(s_tout[1]),
        .Sl_xferAck(s_ack[1]), .user_data_out(u_data[1]), .user_update(u_upd[1]));

    // One bus transfer; returns at the falling edge of the ack cycle with select dropped.
    // lat = cycles from select to ack, -1 on timeout.
    task automatic xfer(input int d, input logic r, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wdat, output int lat, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        abus = a; rnw = r; be = b; dbus = wdat; sel[d] = 1'b1;
        lat = 0; rd = '0; er = 1'b0;
        forever begin
            @(negedge clk);
            if (s_ack[d] || lat > 8) break;
            lat++;
        end
        if (s_ack[d]) begin rd = s_dbus[d]; er = s_err[d]; end
        else lat = -1;
        sel[d] = 1'b0; rnw = 1'b1; be = '0; dbus = '0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_chk++; if ({s_ack[d], s_err[d], s_dbus[d], u_upd[d], s_retry[d], s_tout[d]} !== '0)
                $display("FAIL reset_outputs dut%0d: ack=%b err=%b dbus=%h upd=%b", d, s_ack[d], s_err[d], s_dbus[d], u_upd[d]);
            else n_pass++;
        end
        n_chk++; if (u_data[0] !== {4{32'hA5A5A5A5}}) $display("FAIL reset_data dut0: got %h want %h", u_data[0], {4{32'hA5A5A5A5}}); else n_pass++;
        n_chk++; if (u_data[1] !== 128'h0) $display("FAIL reset_data dut1: got %h want 0", u_data[1]); else n_pass++;
    endtask

    task automatic test_read_init();
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'hA5A5A5A5, 1'b0});
        xfer(0, 1'b1, 32'h0, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if (lat !== 1) $display("FAIL read_init_latency: got %0d want 1", lat); else n_pass++;
        n_chk++; if ({rd, er} !== {e.data, e.err}) $display("FAIL read_init_data: got %h/%b want %h/%b", rd, er, e.data, e.err); else n_pass++;
        @(negedge clk);
        n_chk++; if ({s_ack[0], s_dbus[0]} !== 33'h0) $display("FAIL read_init_after: ack=%b dbus=%h want 0", s_ack[0], s_dbus[0]); else n_pass++;
    endtask

    task automatic test_write_direct();
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'h0, 1'b0});
        xfer(0, 1'b0, 32'h4, 4'hF, 32'h12345678, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if ({lat == 1, rd, er} !== {1'b1, e.data, e.err}) $display("FAIL write_direct_ack: lat=%0d dbus=%h err=%b want 1/0/0", lat, rd, er); else n_pass++;
        n_chk++; if ({u_data[0][63:32], u_upd[0]} !== {32'hA5A5A5A5, 4'b0000}) $display("FAIL write_direct_early: data=%h upd=%b want a5a5a5a5/0000", u_data[0][63:32], u_upd[0]); else n_pass++;
        @(negedge clk);
        n_chk++; if ({u_data[0][63:32], u_upd[0]} !== {32'h12345678, 4'b0010}) $display("FAIL write_direct_n2: data=%h upd=%b want 12345678/0010", u_data[0][63:32], u_upd[0]); else n_pass++;
        @(negedge clk);
        n_chk++; if (u_upd[0] !== 4'b0000) $display("FAIL write_direct_pulse_len: upd=%b want 0000", u_upd[0]); else n_pass++;
        exp_q.push_back('{32'h12345678, 1'b0});
        xfer(0, 1'b1, 32'h4, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if ({rd, er} !== {e.data, e.err}) $display("FAIL write_direct_readback: got %h want %h", rd, e.data); else n_pass++;
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic er; exp_t e;
        xfer(0, 1'b0, 32'h8, 4'b1111, 32'h0, lat, rd, er);
        xfer(0, 1'b0, 32'h8, 4'b0010, 32'hFFFFFFFF, lat, rd, er);
        @(negedge clk);
        n_chk++; if (u_upd[0] !== 4'b0100) $display("FAIL be_pulse: upd=%b want 0100", u_upd[0]); else n_pass++;
        exp_q.push_back('{32'h0000FF00, 1'b0});
        xfer(0, 1'b1, 32'h8, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.data) $display("FAIL be_byte2: got %h want %h", rd, e.data); else n_pass++;
        xfer(0, 1'b0, 32'h8, 4'b1000, 32'hFFFFFFFF, lat, rd, er);
        exp_q.push_back('{32'hFF00FF00, 1'b0});
        xfer(0, 1'b1, 32'h8, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.data) $display("FAIL be_byte0: got %h want %h", rd, e.data); else n_pass++;
        xfer(0, 1'b0, 32'h8, 4'b0000, 32'h0, lat, rd, er);
        n_chk++; if ({lat == 1, er} !== 2'b10) $display("FAIL be_zero_ack: lat=%0d err=%b want 1/0", lat, er); else n_pass++;
        @(negedge clk);
        n_chk++; if ({u_upd[0], u_data[0][95:64]} !== {4'b0000, 32'hFF00FF00}) $display("FAIL be_zero_effect: upd=%b data=%h want 0000/ff00ff00", u_upd[0], u_data[0][95:64]); else n_pass++;
    endtask

    task automatic test_shadow();
        int lat; logic [31:0] rd; logic er; exp_t e;
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h11111111, lat, rd, er);
        @(negedge clk);
        n_chk++; if ({u_data[1], u_upd[1]} !== 132'h0) $display("FAIL shadow_stage0: data=%h upd=%b want 0", u_data[1], u_upd[1]); else n_pass++;
        xfer(1, 1'b0, 32'h4, 4'hF, 32'h22222222, lat, rd, er);
        @(negedge clk);
        n_chk++; if ({u_data[1], u_upd[1]} !== 132'h0) $display("FAIL shadow_stage1: data=%h upd=%b want 0", u_data[1], u_upd[1]); else n_pass++;
        exp_q.push_back('{32'h11111111, 1'b0});
        xfer(1, 1'b1, 32'h0, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.data) $display("FAIL shadow_staged_read: got %h want %h", rd, e.data); else n_pass++;
        xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, rd, er);
        n_chk++; if ({lat == 1, er, u_data[1]} !== {2'b10, 128'h0}) $display("FAIL shadow_commit_early: lat=%0d err=%b data=%h", lat, er, u_data[1]); else n_pass++;
        @(negedge clk);
        n_chk++; if ({u_data[1], u_upd[1]} !== {32'h0, 32'h0, 32'h22222222, 32'h11111111, 4'b1111})
            $display("FAIL shadow_commit: data=%h upd=%b want 0..22222222_11111111/1111", u_data[1], u_upd[1]); else n_pass++;
        @(negedge clk);
        n_chk++; if (u_upd[1] !== 4'b0000) $display("FAIL shadow_pulse_len: upd=%b want 0000", u_upd[1]); else n_pass++;
        exp_q.push_back('{32'h1, 1'b0});
        xfer(1, 1'b1, 32'h10, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.data) $display("FAIL shadow_commit_count: got %h want %h", rd, e.data); else n_pass++;
        // Direct mode: commit word only counts.
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, lat, rd, er);
        @(negedge clk);
        n_chk++; if (u_upd[0] !== 4'b0000) $display("FAIL direct_commit_pulse: upd=%b want 0000", u_upd[0]); else n_pass++;
        exp_q.push_back('{32'h1, 1'b0});
        xfer(0, 1'b1, 32'h10, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if ({rd, er} !== {e.data, e.err}) $display("FAIL direct_commit_count: got %h want %h", rd, e.data); else n_pass++;
    endtask

    task automatic test_unmapped();
        int lat; logic [31:0] rd; logic er; exp_t e; int acks;
        for (int d = 0; d < 2; d++) begin
            exp_q.push_back('{32'h0, 1'b1});
            xfer(d, 1'b1, 32'h14, 4'hF, 32'h0, lat, rd, er);
            e = exp_q.pop_front();
            n_chk++; if ({lat == 1, rd, er} !== {1'b1, e.data, e.err}) $display("FAIL unmapped_read dut%0d: lat=%0d dbus=%h err=%b want 1/0/1", d, lat, rd, er); else n_pass++;
        end
        xfer(0, 1'b0, 32'h14, 4'hF, 32'hFFFFFFFF, lat, rd, er);
        n_chk++; if ({lat == 1, er} !== 2'b11) $display("FAIL unmapped_write_ack: lat=%0d err=%b want 1/1", lat, er); else n_pass++;
        @(negedge clk);
        n_chk++; if ({u_data[0], u_upd[0]} !== {32'hA5A5A5A5, 32'hFF00FF00, 32'h12345678, 32'hA5A5A5A5, 4'b0000})
            $display("FAIL unmapped_write_effect: data=%h upd=%b", u_data[0], u_upd[0]); else n_pass++;
        // Outside the window: another slave's address.
        @(posedge clk); #1;
        abus = 32'h100; rnw = 1'b1; sel[0] = 1'b1; acks = 0;
        repeat (4) begin @(negedge clk); acks += int'(s_ack[0]) + int'(s_err[0]) + int'(s_dbus[0] != 0); end
        sel[0] = 1'b0;
        n_chk++; if (acks !== 0) $display("FAIL nonhit_quiet: activity=%0d want 0", acks); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        @(posedge clk); #1;
        abus = 32'h4; rnw = 1'b1; sel[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin @(negedge clk); pat[i] = s_ack[0]; end
        sel[0] = 1'b0;
        n_chk++; if (pat !== 6'b101010) $display("FAIL back_to_back_acks: got %b want 101010", pat); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_ack();
        int lat; logic [31:0] rd; logic er; exp_t e;
        xfer(0, 1'b0, 32'hC, 4'hF, 32'hDEADBEEF, lat, rd, er);
        n_chk++; if (lat !== 1) $display("FAIL rst_ack_latency: got %0d want 1", lat); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({s_ack[0], s_err[0], u_upd[0], u_data[0][127:96]} !== {2'b00, 4'b0000, 32'hA5A5A5A5})
            $display("FAIL rst_in_ack: ack=%b upd=%b reg3=%h want 0/0000/a5a5a5a5", s_ack[0], u_upd[0], u_data[0][127:96]); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (u_upd[0] !== 4'b0000) $display("FAIL rst_in_ack_pulse: upd=%b want 0000", u_upd[0]); else n_pass++;
        exp_q.push_back('{32'hA5A5A5A5, 1'b0});
        xfer(0, 1'b1, 32'hC, 4'hF, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_chk++; if (rd !== e.data) $display("FAIL rst_in_ack_readback: got %h want %h", rd, e.data); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; sel = '0; abus = '0; dbus = '0; be = '0; rnw = 1'b1; seq_addr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_read_init();
        test_write_direct();
        test_byte_enable();
        test_shadow();
        test_unmapped();
        test_back_to_back();
        test_reset_in_ack();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
